// File: rtl/booth_r4_mult.sv
// Sequential radix-4 Booth multiplier that retires one digit per cycle.
// It handles signed or unsigned operands and keeps an IDLE/RUN/DONE handshake.
module booth_r4_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 tc,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplicator,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 op,
    output logic [1:0]           mux
);
    localparam int unsigned EW = WIDTH + 2;
    localparam int unsigned AW = 2 * WIDTH + 4;
    localparam int unsigned CW = $clog2(WIDTH / 2 + 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_n;
    logic [AW-1:0]   acc, acc_n, xs, addend;
    logic [EW:0]     ys;
    logic [CW-1:0]   cnt, cnt_last;
    logic            tc_r, accept, last, sx, sy;

    assign accept   = start && (state != RUN);
    assign cnt_last = tc_r ? CW'(WIDTH / 2 - 1) : CW'(WIDTH / 2);
    assign last     = (cnt == cnt_last);
    assign sx       = tc & multiplicand[WIDTH-1];
    assign sy       = tc & multiplicator[WIDTH-1];
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last) state_n = DONE;
            DONE:    state_n = start ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Booth digit decode from the low triplet of the shifting multiplicator
    always_comb begin
        op  = 1'b0;
        mux = 2'b00;
        if (state == RUN) begin
            case (ys[2:0])
                3'b001, 3'b010: mux = 2'b01;
                3'b011:         mux = 2'b10;
                3'b100:         begin op = 1'b1; mux = 2'b10; end
                3'b101, 3'b110: begin op = 1'b1; mux = 2'b01; end
                3'b111:         op = 1'b1;
                default:        mux = 2'b00;
            endcase
        end
    end

    // xs already carries the 4^i weight; subtraction is invert plus carry-in
    always_comb begin
        case (mux)
            2'b01:   addend = xs;
            2'b10:   addend = {xs[AW-2:0], 1'b0};
            default: addend = '0;
        endcase
        acc_n = acc + (op ? ~addend : addend) + AW'(op);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            xs      <= '0;
            ys      <= '0;
            cnt     <= '0;
            tc_r    <= 1'b0;
            product <= '0;
        end else if (accept) begin
            acc  <= '0;
            xs   <= {{(AW-WIDTH){sx}}, multiplicand};
            ys   <= {{2{sy}}, multiplicator, 1'b0};
            cnt  <= '0;
            tc_r <= tc;
        end else if (state == RUN) begin
            acc <= acc_n;
            xs  <= xs << 2;
            ys  <= ys >> 2;
            if (last) product <= acc_n[2*WIDTH-1:0];
            else      cnt     <= cnt + CW'(1);
        end
    end
endmodule
